// File: rtl/pipelined_array_multiplier_if.sv
// Operand/product stream bundle for pipelined_array_multiplier: input and output
// valid/ready handshakes plus the pipeline occupancy count.
interface pipelined_array_multiplier_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               SIGNED;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] AB;
  logic [CNT_W-1:0]   pipe_count;

  modport master (
    output in_valid, A, B, SIGNED, out_ready,
    input  in_ready, out_valid, AB, pipe_count
  );

  modport slave (
    input  in_valid, A, B, SIGNED, out_ready,
    output in_ready, out_valid, AB, pipe_count
  );
endinterface

// File: rtl/pipelined_array_multiplier.sv
// Braun-style array multiplier with one partial-product row per stage, signed/unsigned
// per transaction, and a globally stalled valid/ready pipeline.
module pipelined_array_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  pipelined_array_multiplier_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  typedef logic [PW-1:0] sum_t;

  logic [WIDTH-1:0] valid_q, valid_d;
  sum_t             sum_q [WIDTH];
  sum_t             sum_d [WIDTH];
  // The last stage only needs its sum, so operands travel through WIDTH-1 stages.
  logic [WIDTH-1:0] a_q   [WIDTH-1];
  logic [WIDTH-1:0] a_d   [WIDTH-1];
  logic [WIDTH-1:0] b_q   [WIDTH-1];
  logic [WIDTH-1:0] b_d   [WIDTH-1];
  logic [WIDTH-2:0] sgn_q, sgn_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             en;

  function automatic sum_t pp_row(input logic [WIDTH-1:0] a, input logic b_bit,
                                  input logic sgn, input int unsigned k);
    sum_t a_ext;
    a_ext = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    return b_bit ? (a_ext << k) : '0;
  endfunction

  assign en = !valid_q[WIDTH-1] || bus.out_ready;

  always_comb begin
    valid_d = valid_q;
    sum_d   = sum_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    if (en) begin
      valid_d = {valid_q[WIDTH-2:0], bus.in_valid};
      if (bus.in_valid) begin
        sum_d[0] = pp_row(bus.A, bus.B[0], bus.SIGNED, 0);
        a_d[0]   = bus.A;
        b_d[0]   = bus.B;
        sgn_d[0] = bus.SIGNED;
      end
      for (int unsigned k = 1; k < WIDTH; k++) begin
        if (valid_q[k-1]) begin
          // In signed mode the MSB of B carries negative weight.
          if (sgn_q[k-1] && (k == WIDTH - 1)) begin
            sum_d[k] = sum_q[k-1] - pp_row(a_q[k-1], b_q[k-1][k], sgn_q[k-1], k);
          end else begin
            sum_d[k] = sum_q[k-1] + pp_row(a_q[k-1], b_q[k-1][k], sgn_q[k-1], k);
          end
        end
      end
      for (int unsigned k = 1; k < WIDTH - 1; k++) begin
        if (valid_q[k-1]) begin
          a_d[k]   = a_q[k-1];
          b_d[k]   = b_q[k-1];
          sgn_d[k] = sgn_q[k-1];
        end
      end
    end
    count_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      count_d = count_d + CNT_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      sgn_q   <= '0;
      count_q <= '0;
      for (int unsigned k = 0; k < WIDTH; k++) begin
        sum_q[k] <= '0;
      end
      for (int unsigned k = 0; k < WIDTH - 1; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      sgn_q   <= sgn_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign bus.in_ready   = en;
  assign bus.out_valid  = valid_q[WIDTH-1];
  assign bus.AB         = sum_q[WIDTH-1];
  assign bus.pipe_count = count_q;
endmodule

// File: tb/tb_pipelined_array_multiplier.sv
// Directed and randomized checks of pipelined_array_multiplier at WIDTH=4 and WIDTH=8
// against an arithmetic reference product and an in-order scoreboard.
module tb_pipelined_array_multiplier;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pipelined_array_multiplier_if #(.WIDTH(4)) u_if4 ();
  pipelined_array_multiplier_if #(.WIDTH(8)) u_if8 ();

  pipelined_array_multiplier #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(u_if4));
  pipelined_array_multiplier #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(u_if8));

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  int          cyc    = 0;
  logic [15:0] exp4_q [$];
  logic [15:0] exp8_q [$];
  int          acc4_q [$];
  bit          acc4, acc8, lat_en, held8;
  logic [15:0] held8_ab;
  int          ov_run, ov_max, pops4, pops8;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Exact product in the selected interpretation, reduced modulo 2^(2w).
  function automatic logic [15:0] ref_mul(input int unsigned a, input int unsigned b,
                                          input bit s, input int unsigned w);
    longint x, y, p;
    x = longint'(a);
    y = longint'(b);
    if (s) begin
      if (x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
      if (y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
    end
    p = x * y;
    return 16'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic tick();
    int acc_c;
    @(negedge clk);
    acc4 = 1'b0;
    acc8 = 1'b0;
    if (rst_n) begin
      if (u_if4.out_valid) begin
        ov_run++;
        if (ov_run > ov_max) ov_max = ov_run;
      end else begin
        ov_run = 0;
      end
      if (u_if4.out_valid && u_if4.out_ready) begin
        check("w4_out_expected", 32'(exp4_q.size() != 0), 32'd1);
        if (exp4_q.size() != 0) begin
          acc_c = acc4_q.pop_front();
          check("w4_product", 32'(u_if4.AB), 32'(exp4_q.pop_front()));
          if (lat_en) check("w4_latency", 32'(cyc - acc_c), 32'd4);
          pops4++;
        end
      end
      if (u_if4.in_valid && u_if4.in_ready) begin
        exp4_q.push_back(ref_mul(32'(u_if4.A), 32'(u_if4.B), u_if4.SIGNED, 4));
        acc4_q.push_back(cyc);
        acc4 = 1'b1;
      end
      if (held8) begin
        check("w8_hold_valid", 32'(u_if8.out_valid), 32'd1);
        check("w8_hold_ab", 32'(u_if8.AB), 32'(held8_ab));
      end
      held8    = u_if8.out_valid && !u_if8.out_ready;
      held8_ab = u_if8.AB;
      if (u_if8.out_valid && u_if8.out_ready) begin
        check("w8_out_expected", 32'(exp8_q.size() != 0), 32'd1);
        if (exp8_q.size() != 0) begin
          check("w8_product", 32'(u_if8.AB), 32'(exp8_q.pop_front()));
          pops8++;
        end
      end
      if (u_if8.in_valid && u_if8.in_ready) begin
        exp8_q.push_back(ref_mul(32'(u_if8.A), 32'(u_if8.B), u_if8.SIGNED, 8));
        acc8 = 1'b1;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic s);
    int n;
    n              = 0;
    u_if4.in_valid = 1'b1;
    u_if4.A        = a;
    u_if4.B        = b;
    u_if4.SIGNED   = s;
    do begin
      tick();
      n++;
    end while (!acc4 && n < 50);
    check("w4_send_accepted", 32'(acc4), 32'd1);
  endtask

  task automatic drain4();
    int n;
    n              = 0;
    u_if4.in_valid = 1'b0;
    while ((exp4_q.size() != 0 || u_if4.out_valid) && n < 60) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check("w4_drained", 32'(exp4_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int guard;
    u_if4.in_valid  = 1'b0;
    u_if4.A         = '0;
    u_if4.B         = '0;
    u_if4.SIGNED    = 1'b0;
    u_if4.out_ready = 1'b1;
    u_if8.in_valid  = 1'b0;
    u_if8.A         = '0;
    u_if8.B         = '0;
    u_if8.SIGNED    = 1'b0;
    u_if8.out_ready = 1'b1;
    held8           = 1'b0;
    held8_ab        = '0;
    lat_en          = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(u_if4.out_valid), 32'd0);
    check("rst_ab", 32'(u_if4.AB), 32'd0);
    check("rst_pipe_count", 32'(u_if4.pipe_count), 32'd0);
    check("rst_ab_w8", 32'(u_if8.AB), 32'd0);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", 32'(u_if4.in_ready), 32'd1);

    // Unsigned back-to-back stream: fixed latency and unbroken output run.
    ov_run = 0;
    ov_max = 0;
    send4(4'd3, 4'd10, 1'b0);
    send4(4'd12, 4'd10, 1'b0);
    send4(4'd3, 4'd11, 1'b0);
    send4(4'd13, 4'd10, 1'b0);
    send4(4'd15, 4'd15, 1'b0);
    send4(4'd0, 4'd0, 1'b0);
    send4(4'd8, 4'd8, 1'b0);
    drain4();
    check("t1_out_valid_run", 32'(ov_max), 32'd7);
    check("t1_empty_count", 32'(u_if4.pipe_count), 32'd0);

    // Signed corners, then mixed-mode back-to-back.
    send4(4'h8, 4'h8, 1'b1);
    send4(4'h8, 4'h7, 1'b1);
    send4(4'hF, 4'h1, 1'b1);
    send4(4'h7, 4'h7, 1'b1);
    drain4();
    send4(4'hF, 4'hF, 1'b0);
    send4(4'hF, 4'hF, 1'b1);
    drain4();

    // Backpressure: fill the pipe, hold, then release and drain in order.
    lat_en          = 1'b0;
    pops4           = 0;
    u_if4.out_ready = 1'b0;
    send4(4'd1, 4'd2, 1'b0);
    send4(4'd3, 4'd4, 1'b0);
    send4(4'd5, 4'd6, 1'b0);
    send4(4'd7, 4'd8, 1'b0);
    u_if4.in_valid = 1'b1;
    u_if4.A        = 4'd9;
    u_if4.B        = 4'd10;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_full_count", 32'(u_if4.pipe_count), 32'd4);
      check("t4_in_ready", 32'(u_if4.in_ready), 32'd0);
      check("t4_held_valid", 32'(u_if4.out_valid), 32'd1);
      check("t4_held_ab", 32'(u_if4.AB), 32'(ref_mul(1, 2, 1'b0, 4)));
    end
    u_if4.out_ready = 1'b1;
    send4(4'd9, 4'd10, 1'b0);
    send4(4'd11, 4'd12, 1'b0);
    drain4();
    check("t4_drain_count", 32'(pops4), 32'd6);

    // Reset with three stages occupied; nothing stale may surface afterwards.
    lat_en = 1'b1;
    send4(4'd2, 4'd3, 1'b0);
    send4(4'd4, 4'd5, 1'b0);
    send4(4'd6, 4'd7, 1'b0);
    u_if4.in_valid = 1'b0;
    check("t5_count_before", 32'(u_if4.pipe_count), 32'd3);
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", 32'(u_if4.out_valid), 32'd0);
    check("t5_rst_ab", 32'(u_if4.AB), 32'd0);
    check("t5_rst_count", 32'(u_if4.pipe_count), 32'd0);
    exp4_q.delete();
    acc4_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("t5_in_ready", 32'(u_if4.in_ready), 32'd1);
    pops4 = 0;
    send4(4'd5, 4'd5, 1'b0);
    drain4();
    check("t5_single_result", 32'(pops4), 32'd1);

    // WIDTH=8 random stream with random backpressure and mixed modes.
    n     = 0;
    guard = 0;
    pops8 = 0;
    while (n < 10000 && guard < 60000) begin
      if (n == 0) begin
        u_if8.in_valid = 1'b1;
        u_if8.A        = 8'd255;
        u_if8.B        = 8'd255;
        u_if8.SIGNED   = 1'b0;
      end else if (n == 1) begin
        u_if8.in_valid = 1'b1;
        u_if8.A        = 8'h80;
        u_if8.B        = 8'h80;
        u_if8.SIGNED   = 1'b1;
      end else begin
        u_if8.in_valid = ($urandom_range(0, 9) < 8);
        u_if8.A        = 8'($urandom);
        u_if8.B        = 8'($urandom);
        u_if8.SIGNED   = 1'($urandom);
      end
      u_if8.out_ready = ($urandom_range(0, 9) < 7);
      tick();
      guard++;
      if (acc8) n++;
    end
    check("w8_all_sent", 32'(n), 32'd10000);
    u_if8.in_valid  = 1'b0;
    u_if8.out_ready = 1'b1;
    guard           = 0;
    while ((exp8_q.size() != 0 || u_if8.out_valid) && guard < 100) begin
      tick();
      guard++;
    end
    repeat (3) tick();
    check("w8_drained", 32'(exp8_q.size()), 32'd0);
    check("w8_result_count", 32'(pops8), 32'd10000);
    check("w8_empty_count", 32'(u_if8.pipe_count), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
